sdfm_irq_ctrl: RTL and testbench

- Interrupt/status controller downstream of the per-channel sigma-delta channel blocks.
- Consumes each channel's event outputs: filter data update, comparator low/high, FIFO level/full and clock-detect error.
- Latches per-channel sticky flags and gates them with enables.
- Drives one master interrupt flag plus a one-cycle interrupt pulse to the CPU interface.

---
 rtl/sdfm_pkg.sv | 19 +
 rtl/sdfm_irq_chan.sv | 62 ++++++
 rtl/sdfm_irq_ctrl.sv | 66 ++++++
 tb/tb_sdfm_irq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sdfm_pkg.sv
// Shared definitions for the sigma-delta interrupt/status controller.
package sdfm_pkg;

   // Flags per channel; the bit order inside a channel's slice is fixed.
   localparam int NFLG = 6;

   localparam int FLG_DRDY = 0;   // filter data ready
   localparam int FLG_OVF  = 1;   // data overrun or FIFO full
   localparam int FLG_CMPL = 2;   // comparator below low threshold
   localparam int FLG_CMPH = 3;   // comparator at/above high threshold
   localparam int FLG_FLVL = 4;   // FIFO interrupt level reached
   localparam int FLG_CERR = 5;   // input clock error

   // Rising-edge detect against a registered previous value.
   function automatic logic rise(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/sdfm_irq_chan.sv
// One channel: edge detectors on the level sources, DRDY/OVF handling and
// the six sticky flag registers. Set wins over a same-cycle clear.
module sdfm_irq_chan
   import sdfm_pkg::*;
(
   input  logic            clk_sys,
   input  logic            rst_b,
   input  logic            filtask,
   input  logic            data_update,
   input  logic            comp_low,
   input  logic            comp_high,
   input  logic            fifo_lvlup,
   input  logic            fifo_full,
   input  logic            detect_err,
   input  logic [NFLG-1:0] clr,
   output logic [NFLG-1:0] flg
);

   logic            prev_low;
   logic            prev_high;
   logic            prev_lvlup;
   logic            prev_full;
   logic            prev_err;
   logic            overrun;
   logic [NFLG-1:0] set;

   // Overrun only in acknowledge mode: a new sample while DRDY is still
   // pending and not being acknowledged in this same cycle.
   assign overrun = data_update & filtask & flg[FLG_DRDY] & ~clr[FLG_DRDY];

   // Per-flag set terms; DRDY is simply re-set on overrun, it is already 1.
   always_comb begin
      set           = '0;
      set[FLG_DRDY] = data_update;
      set[FLG_OVF]  = overrun | rise(fifo_full, prev_full);
      set[FLG_CMPL] = rise(comp_low, prev_low);
      set[FLG_CMPH] = rise(comp_high, prev_high);
      set[FLG_FLVL] = rise(fifo_lvlup, prev_lvlup);
      set[FLG_CERR] = rise(detect_err, prev_err);
   end

   // Edge history and sticky flags; history clears to 0 so a level already
   // high at reset release is reported once.
   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         prev_low   <= 1'b0;
         prev_high  <= 1'b0;
         prev_lvlup <= 1'b0;
         prev_full  <= 1'b0;
         prev_err   <= 1'b0;
         flg        <= '0;
      end else begin
         prev_low   <= comp_low;
         prev_high  <= comp_high;
         prev_lvlup <= fifo_lvlup;
         prev_full  <= fifo_full;
         prev_err   <= detect_err;
         flg        <= set | (flg & ~clr);
      end
   end

endmodule

// File: rtl/sdfm_irq_ctrl.sv
// Interrupt/status controller for the sigma-delta channels: per-channel
// sticky flags, enable gating, master interrupt flag and one-cycle irq.
module sdfm_irq_ctrl
   import sdfm_pkg::*;
#(
   parameter int CH = 4
)(
   input  logic               SYSCLK,
   input  logic               SYSRSTn,
   input  logic               reg_mien,
   input  logic [NFLG*CH-1:0] reg_ien,
   input  logic [CH-1:0]      reg_filtask,
   input  logic [CH-1:0]      filt_data_update,
   input  logic [CH-1:0]      comp_data_low,
   input  logic [CH-1:0]      comp_data_high,
   input  logic [CH-1:0]      fifo_lvlup,
   input  logic [CH-1:0]      fifo_full,
   input  logic [CH-1:0]      detect_err,
   input  logic [NFLG*CH-1:0] flg_clr,
   input  logic               mif_clr,
   output logic [NFLG*CH-1:0] flg,
   output logic               mif,
   output logic               irq
);

   logic pend;
   logic mif_set;

   for (genvar k = 0; k < CH; k++) begin : g_chan
      sdfm_irq_chan u_chan (
         .clk_sys     (SYSCLK),
         .rst_b       (SYSRSTn),
         .filtask     (reg_filtask[k]),
         .data_update (filt_data_update[k]),
         .comp_low    (comp_data_low[k]),
         .comp_high   (comp_data_high[k]),
         .fifo_lvlup  (fifo_lvlup[k]),
         .fifo_full   (fifo_full[k]),
         .detect_err  (detect_err[k]),
         .clr         (flg_clr[k*NFLG +: NFLG]),
         .flg         (flg[k*NFLG +: NFLG])
      );
   end

   assign pend = reg_mien & (|(flg & reg_ien));

   // A clear cycle never sets; if pend survives the clear, mif re-arms on
   // the following edge so no interrupt is lost.
   assign mif_set = pend & ~mif & ~mif_clr;

   // Master flag and its one-cycle pulse; irq follows mif_set so it can
   // never be high twice in a row (mif is 1 on the cycle after a set).
   always_ff @(posedge SYSCLK) begin
      if (!SYSRSTn) begin
         mif <= 1'b0;
         irq <= 1'b0;
      end else begin
         irq <= mif_set;
         if (mif_set)
            mif <= 1'b1;
         else if (mif_clr)
            mif <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdfm_irq_ctrl.sv
// Scoreboard bench for sdfm_irq_ctrl: stimulus pushes expected snapshots
// tagged with the edge after which they must hold; a monitor pops them.
module tb_sdfm_irq_ctrl;
   localparam int CH = 4;
   localparam int W  = 24;

   logic          SYSCLK = 1'b0;
   logic          SYSRSTn;
   logic          reg_mien;
   logic [W-1:0]  reg_ien;
   logic [CH-1:0] reg_filtask, filt_data_update, comp_data_low, comp_data_high;
   logic [CH-1:0] fifo_lvlup, fifo_full, detect_err;
   logic [W-1:0]  flg_clr;
   logic          mif_clr;
   logic [W-1:0]  flg;
   logic          mif, irq;

   sdfm_irq_ctrl #(.CH(CH)) dut (
      .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn), .reg_mien(reg_mien), .reg_ien(reg_ien),
      .reg_filtask(reg_filtask), .filt_data_update(filt_data_update),
      .comp_data_low(comp_data_low), .comp_data_high(comp_data_high),
      .fifo_lvlup(fifo_lvlup), .fifo_full(fifo_full), .detect_err(detect_err),
      .flg_clr(flg_clr), .mif_clr(mif_clr), .flg(flg), .mif(mif), .irq(irq)
   );

   always #5 SYSCLK = ~SYSCLK;

   typedef struct {
      int           cyc;
      string        nm;
      logic [W-1:0] flg;
      logic         mif;
      logic         irq;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge SYSCLK) edge_cnt <= edge_cnt + 1;

   // Monitor: compare every snapshot due at this edge, away from the edge.
   always @(negedge SYSCLK) begin
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
         exp_t e;
         e = q.pop_front();
         n_chk++;
         if (flg !== e.flg) begin
            n_fail++;
            $display("FAIL %s flg: got %h want %h", e.nm, flg, e.flg);
         end
         n_chk++;
         if (mif !== e.mif) begin
            n_fail++;
            $display("FAIL %s mif: got %b want %b", e.nm, mif, e.mif);
         end
         n_chk++;
         if (irq !== e.irq) begin
            n_fail++;
            $display("FAIL %s irq: got %b want %b", e.nm, irq, e.irq);
         end
      end
   end

   task automatic step();
      @(posedge SYSCLK);
      #1;
   endtask

   // Expect the given outputs after n more active edges.
   task automatic push(input int n, input string nm, input logic [W-1:0] f,
                       input logic m, input logic i);
      exp_t e;
      e.cyc = edge_cnt + n;
      e.nm  = nm;
      e.flg = f;
      e.mif = m;
      e.irq = i;
      q.push_back(e);
   endtask

   task automatic clear_all(input string nm);
      flg_clr = '1;
      mif_clr = 1'b1;
      step();
      flg_clr = '0;
      mif_clr = 1'b0;
      push(0, nm, 24'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      SYSRSTn = 1'b0; reg_mien = 1'b1; reg_ien = 24'h000008;
      reg_filtask = '0; filt_data_update = '0; comp_data_low = '0;
      comp_data_high = 4'b0001; fifo_lvlup = '0; fifo_full = '0;
      detect_err = '0; flg_clr = '0; mif_clr = 1'b0;

      // Reset with comp_data_high[0] already high.
      repeat (3) step();
      push(0, "reset", 24'h0, 1'b0, 1'b0);
      SYSRSTn = 1'b1;
      push(1, "rel_flg",  24'h000008, 1'b0, 1'b0);
      push(2, "rel_irq",  24'h000008, 1'b1, 1'b1);
      push(3, "rel_idle", 24'h000008, 1'b1, 1'b0);
      repeat (3) step();
      reg_ien = '0;
      clear_all("clr1");

      // DRDY / overrun in acknowledge mode.
      reg_filtask = 4'b0010;
      filt_data_update = 4'b0010; step(); filt_data_update = '0;
      push(0, "drdy1", 24'h000040, 1'b0, 1'b0);
      filt_data_update = 4'b0010; step(); filt_data_update = '0;
      push(0, "ovf1", 24'h0000C0, 1'b0, 1'b0);
      clear_all("clr2");
      reg_filtask = '0;
      filt_data_update = 4'b0010; step(); filt_data_update = '0;
      push(0, "drdy2", 24'h000040, 1'b0, 1'b0);
      filt_data_update = 4'b0010; step(); filt_data_update = '0;
      push(0, "no_ovf", 24'h000040, 1'b0, 1'b0);
      // Acknowledge in the same cycle as a new sample: no overrun.
      reg_filtask = 4'b0010;
      filt_data_update = 4'b0010; flg_clr = 24'h000040; step();
      filt_data_update = '0; flg_clr = '0;
      push(0, "ack_same", 24'h000040, 1'b0, 1'b0);
      reg_filtask = '0;
      fifo_full = 4'b0100; fifo_lvlup = 4'b0010; step();
      push(0, "full_lvl", 24'h002440, 1'b0, 1'b0);
      fifo_full = '0; fifo_lvlup = '0;
      clear_all("clr3");

      // Set beats a same-cycle clear.
      comp_data_low = 4'b0001; step();
      push(0, "cmpl", 24'h000004, 1'b0, 1'b0);
      comp_data_low = '0; step();
      push(0, "cmpl_hold", 24'h000004, 1'b0, 1'b0);
      comp_data_low = 4'b0001; flg_clr = 24'h000004; step(); flg_clr = '0;
      push(0, "set_wins", 24'h000004, 1'b0, 1'b0);
      flg_clr = 24'h000004; step(); flg_clr = '0;
      push(0, "clr_only", 24'h0, 1'b0, 1'b0);
      comp_data_low = '0;

      // mif clear with pend still active re-triggers.
      reg_mien = 1'b1; reg_ien = 24'h000020;
      detect_err = 4'b0001; step();
      push(0, "cerr", 24'h000020, 1'b0, 1'b0);
      step(); push(0, "cerr_irq", 24'h000020, 1'b1, 1'b1);
      comp_data_high = 4'b0011; step();
      push(0, "no_reirq", 24'h000220, 1'b1, 1'b0);
      mif_clr = 1'b1; step(); mif_clr = 1'b0;
      push(0, "mifclr", 24'h000220, 1'b0, 1'b0);
      step(); push(0, "retrig", 24'h000220, 1'b1, 1'b1);
      step(); push(0, "retrig_off", 24'h000220, 1'b1, 1'b0);
      detect_err = '0; comp_data_high = 4'b0001;
      clear_all("clr4");

      // Master enable gating.
      reg_mien = 1'b0; reg_ien = 24'h800000;
      detect_err = 4'b1000; step();
      push(0, "mien0_a", 24'h800000, 1'b0, 1'b0);
      step(); push(0, "mien0_b", 24'h800000, 1'b0, 1'b0);
      reg_mien = 1'b1; step();
      push(0, "mien1", 24'h800000, 1'b1, 1'b1);
      step(); push(0, "mien1_off", 24'h800000, 1'b1, 1'b0);
      reg_mien = 1'b0; step();
      push(0, "mif_hold", 24'h800000, 1'b1, 1'b0);
      detect_err = '0;
      clear_all("clr5");

      // Reset after an event, before mif sets.
      reg_mien = 1'b1; reg_ien = '1;
      comp_data_high = 4'b0101; step();
      push(0, "pre_rst", 24'h008000, 1'b0, 1'b0);
      SYSRSTn = 1'b0; comp_data_high = '0; step();
      push(0, "mid_rst", 24'h0, 1'b0, 1'b0);
      SYSRSTn = 1'b1;
      push(1, "post_rst1", 24'h0, 1'b0, 1'b0);
      push(2, "post_rst2", 24'h0, 1'b0, 1'b0);
      push(3, "post_rst3", 24'h0, 1'b0, 1'b0);
      repeat (5) step();

      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
